mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Multi-cycle data-memory access controller for the MEM stage of the 5-stage RV32I pipeline. Converts the single-cycle load/store request of the instruction in MEM into a req/ack transaction on a variable-latency data bus. It raises `stall_mem` toward the hazard unit, which freezes F/D/E/M until the access completes. It also performs byte-lane steering for stores and sign/zero extension for loads.

## Interface
- `ADDR_WIDTH`, default 32: byte address width.
- `DATA_WIDTH`, default 32: bus data width; only 32 is supported.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `memread_m` in 1: load in MEM.
- `memwrite_m` in 1: store in MEM; never asserted together with `memread_m`.
- `addr_m` in 32: byte address (ALU result).
- `wdata_m` in 32: store data (rs2).
- `funct3_m` in 3: access size and sign.
- `rdata_m` out 32: extended load data; valid in DONE.
- `stall_mem` out 1: freeze request to the hazard unit.
- `err_m` out 1: misaligned access flag.
- `bus_req` out 1: transaction request.
- `bus_we` out 1: 1 = write.
- `bus_addr` out 32: word-aligned address, with `addr_m[1:0]` forced to 0.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_be` out 4: byte enables.
- `bus_ack` in 1: completion, a one-cycle pulse.
- `bus_rdata` in 32: read word, valid with `bus_ack`.

## Operation
- **FSM states:** IDLE, REQ, DONE.
- **IDLE:**
  - On a valid access (`memread_m|memwrite_m`, aligned), latch addr/we/wdata/be/funct3/lane and go to REQ.
  - `stall_mem` = 1 combinationally in this cycle.
- **REQ:**
  - `bus_req` = 1; `bus_addr`/`bus_we`/`bus_wdata`/`bus_be` stay stable until `bus_ack` is sampled high.
  - `stall_mem` = 1.
  - On `bus_ack`, capture `bus_rdata` and go to DONE.
- **DONE:**
  - `stall_mem` = 0 and `bus_req` = 0; `rdata_m` is driven from the captured word, so the pipeline advances this edge.
  - Next state is IDLE unconditionally.
  - This prevents re-issuing the access for the same instruction.
- **Byte enables:**
  - SB (000): `4'b0001 << addr[1:0]`.
  - SH (001): `4'b0011 << addr[1:0]`.
  - SW (010): `4'b1111`.
  - Loads drive `bus_be` = 4'b1111.
- **Store data:** SB replicates `wdata_m[7:0]` ×4; SH replicates `[15:0]` ×2; SW passes through.
- **Load extension:**
  - LB (000) and LH (001) sign-extend the selected lane; LBU (100) and LHU (101) zero-extend; LW (010) passes through.
  - Lane is `addr[1:0]` for bytes and `addr[1]` for halves.
- **Misaligned access** (LH/LHU/SH with `addr[0]`=1; LW/SW with `addr[1:0]`≠0):
  - `err_m` = 1 combinationally in IDLE; `stall_mem` = 0; no bus transaction; `rdata_m` = 0.
- **Idle outputs:** no access → `stall_mem` = 0, `rdata_m` = 0.
- **Input stability:** MEM inputs are held stable by the hazard unit while `stall_mem` = 1; the block does not re-sample them after IDLE.
- **Stray ack:** a `bus_ack` outside REQ is ignored.

## Timing
- **Reset** (`rst_n` low at an edge, including mid-transaction):
  - state → IDLE; `bus_req`, `bus_we`, `bus_be`, captured data, and `rdata_m` → 0; any pending store-buffer entry is dropped.
  - `stall_mem` and `err_m` are 0 during reset.
- **Latency:**
  - Access seen in cycle N → `bus_req` high in N+1.
  - Ack in cycle N+1+W (W ≥ 0 wait cycles) → DONE in N+2+W.
  - Total stall is 2+W cycles.
- **Request rules:**
  - `bus_req` is a registered output.
  - It falls in the cycle after ack.
  - At least one idle cycle separates consecutive requests.
- **Back-to-back accesses:** the access after DONE is seen in IDLE on the next cycle and restarts the sequence.

## Configuration
- **`MEM_STORE_BUFFER_EN` defined:** one-entry posted store buffer.
  - Store in IDLE with the buffer empty: entry loaded, `stall_mem` = 0 that cycle, instruction retires.
  - The buffer drains via REQ independently.
  - Any access (load or store) arriving while the buffer is occupied stalls until the drain's ack and is then handled normally.
  - A load to the same word as a buffered store must not be serviced before the drain completes.
- **Undefined:** stores use the full IDLE→REQ→DONE path like loads.

## Test plan
- **Zero-wait LW:**
  - Stimulus: `addr_m`=0x100, ack in first REQ cycle with `bus_rdata`=0xDEADBEEF.
  - Response: `stall_mem` high exactly 2 cycles; `rdata_m`=0xDEADBEEF in DONE; `bus_addr`=0x100.
- **LB/LBU:**
  - Stimulus: `addr_m`=0x103, `bus_rdata`=0x80FF_0000.
  - Response: LB → 0xFFFFFF80; LBU → 0x00000080.
- **SH with wait states:**
  - Stimulus: `addr_m`=0x202, `wdata_m`=0x1234ABCD, ack after 3 wait cycles.
  - Response: `bus_be`=0b1100; `bus_wdata`=0xABCDABCD; bus signals stable 4 cycles; `stall_mem` high 5 cycles.
- **Misaligned LW:**
  - Stimulus: `addr_m`=0x101.
  - Response: `err_m`=1, `stall_mem`=0, `bus_req` never rises.
- **Reset mid-REQ:**
  - Stimulus: `rst_n` low during wait states.
  - Response: next cycle `bus_req`=0, `stall_mem`=0, state IDLE; a late `bus_ack` is ignored.
- **With `MEM_STORE_BUFFER_EN`:**
  - Stimulus: SW followed immediately by LW to the same word.
  - Response: SW retires with 0 stall; LW stalls until the store's ack, then issues its read.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: req/ack data-bus access, store lane steering, load extension.
// Latency: bus_req one cycle after the access is seen; rdata_m in DONE, stall_mem held for 2+W cycles.
// Backpressure: stall_mem freezes the pipe until bus_ack; MEM_STORE_BUFFER_EN posts one store.
module mem_access_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  memread_m,
    input  logic                  memwrite_m,
    input  logic [ADDR_WIDTH-1:0] addr_m,
    input  logic [DATA_WIDTH-1:0] wdata_m,
    input  logic [2:0]            funct3_m,
    output logic [DATA_WIDTH-1:0] rdata_m,
    output logic                  stall_mem,
    output logic                  err_m,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    output logic [3:0]            bus_be,
    input  logic                  bus_ack,
    input  logic [DATA_WIDTH-1:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t                state, state_next;
    logic                  access, misaligned, start, post_store;
    logic [3:0]            be_next;
    logic [DATA_WIDTH-1:0] wdata_next;
    logic [DATA_WIDTH-1:0] cap_data, load_ext;
    logic [2:0]            lat_f3;
    logic [1:0]            lat_off;
    logic [7:0]            lane_b;
    logic [15:0]           lane_h;
    logic                  sb_vld;

    assign access = memread_m | memwrite_m;
    assign start  = (state == IDLE) && access && !misaligned;

    always_comb begin
        misaligned = 1'b0;
        case (funct3_m[1:0])
            2'b01:   misaligned = addr_m[0];
            2'b10:   misaligned = |addr_m[1:0];
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        be_next    = 4'b1111;
        wdata_next = wdata_m;
        if (memwrite_m) begin
            case (funct3_m[1:0])
                2'b00: begin
                    be_next    = 4'b0001 << addr_m[1:0];
                    wdata_next = {4{wdata_m[7:0]}};
                end
                2'b01: begin
                    be_next    = 4'b0011 << addr_m[1:0];
                    wdata_next = {2{wdata_m[15:0]}};
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_STORE_BUFFER_EN
    // A posted store retires at once; sb_vld marks the REQ phase as its drain.
    always_ff @(posedge clk) begin
        if (!rst_n)
            sb_vld <= 1'b0;
        else if (start && memwrite_m)
            sb_vld <= 1'b1;
        else if (state == REQ && bus_ack)
            sb_vld <= 1'b0;
    end
    assign post_store = memwrite_m;
`else
    assign sb_vld     = 1'b0;
    assign post_store = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = REQ;
            REQ:     if (bus_ack) state_next = sb_vld ? IDLE : DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stall_mem = 1'b0;
        err_m     = 1'b0;
        rdata_m   = '0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    err_m     = access & misaligned;
                    stall_mem = start & ~post_store;
                end
                // While a posted store drains, only a newly arrived access waits.
                REQ:     stall_mem = sb_vld ? access : 1'b1;
                DONE:    rdata_m = load_ext;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_be    <= 4'b0000;
            lat_f3    <= 3'b000;
            lat_off   <= 2'b00;
            cap_data  <= '0;
        end else begin
            bus_req <= (state_next == REQ);
            if (start) begin
                bus_we    <= memwrite_m;
                bus_addr  <= {addr_m[ADDR_WIDTH-1:2], 2'b00};
                bus_wdata <= wdata_next;
                bus_be    <= be_next;
                lat_f3    <= funct3_m;
                lat_off   <= addr_m[1:0];
            end
            if (state == REQ && bus_ack)
                cap_data <= bus_rdata;
        end
    end

    always_comb begin
        lane_b   = cap_data[{lat_off, 3'b000} +: 8];
        lane_h   = lat_off[1] ? cap_data[31:16] : cap_data[15:0];
        load_ext = cap_data;
        case (lat_f3)
            3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
            3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
            3'b100:  load_ext = {24'b0, lane_b};
            3'b101:  load_ext = {16'b0, lane_h};
            default: load_ext = cap_data;
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: expected bus transactions and load results are
// queued as each access is driven and retired as the DUT issues requests and completes.
module tb_mem_access_ctrl;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_txn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        memread_m, memwrite_m;
    logic [31:0] addr_m, wdata_m, rdata_m;
    logic [2:0]  funct3_m;
    logic        stall_mem, err_m, bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int vectors    = 0;
    int miscompares = 0;

    bus_txn_t    exp_bus_q[$];
    logic [31:0] exp_rd_q[$];

    mem_access_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .memread_m(memread_m), .memwrite_m(memwrite_m),
        .addr_m(addr_m), .wdata_m(wdata_m), .funct3_m(funct3_m),
        .rdata_m(rdata_m), .stall_mem(stall_mem), .err_m(err_m),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    function automatic bus_txn_t exp_txn(input logic we, input logic [31:0] addr,
                                         input logic [31:0] wd, input logic [2:0] f3);
        bus_txn_t t;
        t.we    = we;
        t.addr  = {addr[31:2], 2'b00};
        t.be    = 4'b1111;
        t.wdata = wd;
        if (we) begin
            case (f3)
                3'b000: begin t.be = 4'b0001 << addr[1:0]; t.wdata = {4{wd[7:0]}}; end
                3'b001: begin t.be = 4'b0011 << addr[1:0]; t.wdata = {2{wd[15:0]}}; end
                default: ;
            endcase
        end
        return t;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [31:0] s;
        logic [7:0]  b;
        logic [15:0] h;
        s = w >> (8 * off);
        b = s[7:0];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    task automatic clear_inputs;
        memread_m  = 1'b0;
        memwrite_m = 1'b0;
        addr_m     = 32'h0;
        wdata_m    = 32'h0;
        funct3_m   = 3'b000;
    endtask

    // Drives one access from IDLE and follows it to completion; entered and left at posedge+1.
    task automatic run_access(input string nm, input logic rd, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [2:0] f3, input int waits,
                              input logic [31:0] rword, input int exp_stall);
        int stall_cnt = 0;
        int req_cnt   = 0;
        int guard     = 0;
        bit done      = 0;
        bus_txn_t t;
        logic [31:0] er;
        exp_bus_q.push_back(exp_txn(!rd, addr, wd, f3));
        if (rd) exp_rd_q.push_back(exp_load(f3, addr[1:0], rword));
        memread_m = rd; memwrite_m = !rd; addr_m = addr; wdata_m = wd; funct3_m = f3;
        while (!done && guard < 40) begin
            @(negedge clk);
            guard++;
            if (bus_req) begin
                req_cnt++;
                vectors++;
                if (exp_bus_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL %s unexpected_req: bus_req=1 with no pending transaction", nm);
                end else begin
                    t = exp_bus_q[0];
                    if ({bus_we, bus_addr, bus_be} !== {t.we, t.addr, t.be} ||
                        (t.we && bus_wdata !== t.wdata)) begin
                        miscompares++;
                        $display("FAIL %s bus_fields: got we=%b addr=%h be=%b wdata=%h, want we=%b addr=%h be=%b wdata=%h",
                                 nm, bus_we, bus_addr, bus_be, bus_wdata, t.we, t.addr, t.be, t.wdata);
                    end
                    if (req_cnt == waits + 1) begin
                        bus_ack = 1'b1;
                        bus_rdata = rword;
                        void'(exp_bus_q.pop_front());
                    end
                end
            end
            if (stall_mem) stall_cnt++;
            else begin
                done = 1;
                if (rd && exp_rd_q.size() > 0) begin
                    er = exp_rd_q.pop_front();
                    vectors++;
                    if (rdata_m !== er) begin
                        miscompares++;
                        $display("FAIL %s rdata: got %h, want %h", nm, rdata_m, er);
                    end
                end
            end
            @(posedge clk); #1;
            bus_ack = 1'b0;
        end
        clear_inputs();
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL %s timeout: stall still high after %0d cycles, want release", nm, guard);
        end
        vectors++;
        if (stall_cnt !== exp_stall) begin
            miscompares++;
            $display("FAIL %s stall_cycles: got %0d, want %0d", nm, stall_cnt, exp_stall);
        end
        vectors++;
        if (req_cnt !== waits + 1) begin
            miscompares++;
            $display("FAIL %s req_cycles: got %0d, want %0d", nm, req_cnt, waits + 1);
        end
        exp_bus_q.delete();
        exp_rd_q.delete();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        clear_inputs();
        memread_m = 1'b1; addr_m = 32'h100; funct3_m = 3'b010;
        bus_ack = 1'b0; bus_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({stall_mem, err_m, bus_req, bus_we, bus_be} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_ctrl: got stall=%b err=%b req=%b we=%b be=%b, want all 0",
                     stall_mem, err_m, bus_req, bus_we, bus_be);
        end
        vectors++;
        if (rdata_m !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rdata: got %h, want 00000000", rdata_m);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_inputs();
        @(negedge clk);
        vectors++;
        if ({stall_mem, bus_req} !== 2'b00) begin
            miscompares++;
            $display("FAIL idle_no_access: got stall=%b req=%b, want 0 0", stall_mem, bus_req);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_lw_zero_wait;
        run_access("lw_zero_wait", 1'b1, 32'h100, 32'h0, 3'b010, 0, 32'hDEADBEEF, 2);
    endtask

    task automatic test_load_ext;
        run_access("lb_103",  1'b1, 32'h103, 32'h0, 3'b000, 0, 32'h80FF0000, 2);
        run_access("lbu_103", 1'b1, 32'h103, 32'h0, 3'b100, 1, 32'h80FF0000, 3);
        run_access("lh_102",  1'b1, 32'h102, 32'h0, 3'b001, 0, 32'h80FF0000, 2);
        run_access("lhu_102", 1'b1, 32'h102, 32'h0, 3'b101, 2, 32'h80FF0000, 4);
        run_access("lh_100",  1'b1, 32'h100, 32'h0, 3'b001, 0, 32'h00008001, 2);
        for (int i = 0; i < 4; i++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            int w;
            case (i)
                0: f3 = 3'b000;
                1: f3 = 3'b100;
                2: f3 = 3'b001;
                default: f3 = 3'b101;
            endcase
            a = {$urandom_range(16'hFFFF, 0), 14'h0, 2'($urandom_range(3, 0))};
            if (f3[0]) a[0] = 1'b0;
            w = $urandom_range(2, 0);
            run_access("load_rand", 1'b1, a, 32'h0, f3, w, $urandom, 2 + w);
        end
    endtask

`ifndef MEM_STORE_BUFFER_EN
    task automatic test_store;
        run_access("sh_wait3", 1'b0, 32'h202, 32'h1234ABCD, 3'b001, 3, 32'h0, 5);
        run_access("sb_201",   1'b0, 32'h201, 32'h000000EF, 3'b000, 0, 32'h0, 2);
        run_access("sw_204",   1'b0, 32'h204, 32'h11223344, 3'b010, 1, 32'h0, 3);
    endtask
`endif

    task automatic test_misaligned;
        memread_m = 1'b1; addr_m = 32'h101; funct3_m = 3'b010;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if ({err_m, stall_mem, bus_req} !== 3'b100 || rdata_m !== 32'h0) begin
                miscompares++;
                $display("FAIL misaligned_lw: got err=%b stall=%b req=%b rdata=%h, want 1 0 0 0",
                         err_m, stall_mem, bus_req, rdata_m);
            end
            @(posedge clk); #1;
        end
        memread_m = 1'b0; memwrite_m = 1'b1; addr_m = 32'h203; funct3_m = 3'b001;
        @(negedge clk);
        vectors++;
        if ({err_m, stall_mem} !== 2'b10) begin
            miscompares++;
            $display("FAIL misaligned_sh: got err=%b stall=%b, want 1 0", err_m, stall_mem);
        end
        @(posedge clk); #1;
        clear_inputs();
        @(negedge clk);
        vectors++;
        if ({err_m, bus_req} !== 2'b00) begin
            miscompares++;
            $display("FAIL misaligned_after: got err=%b req=%b, want 0 0", err_m, bus_req);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        run_access("b2b_first",  1'b1, 32'h500, 32'h0, 3'b010, 0, 32'h01234567, 2);
        run_access("b2b_second", 1'b1, 32'h504, 32'h0, 3'b010, 0, 32'h89ABCDEF, 2);
    endtask

    task automatic test_reset_mid_req;
        int guard = 0;
        memread_m = 1'b1; addr_m = 32'h400; funct3_m = 3'b010;
        do begin
            @(negedge clk);
            guard++;
        end while (!bus_req && guard < 10);
        vectors++;
        if (!bus_req) begin
            miscompares++;
            $display("FAIL rst_mid_req_setup: got bus_req=0, want 1");
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (stall_mem !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_req_stall: got stall=%b, want 0", stall_mem);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_inputs();
        bus_ack = 1'b1; bus_rdata = 32'hBADBAD00;
        @(negedge clk);
        vectors++;
        if ({bus_req, stall_mem} !== 2'b00 || rdata_m !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_mid_req_idle: got req=%b stall=%b rdata=%h, want 0 0 0",
                     bus_req, stall_mem, rdata_m);
        end
        @(posedge clk); #1;
        bus_ack = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus_req, stall_mem} !== 2'b00 || rdata_m !== 32'h0) begin
            miscompares++;
            $display("FAIL stray_ack: got req=%b stall=%b rdata=%h, want 0 0 0",
                     bus_req, stall_mem, rdata_m);
        end
        @(posedge clk); #1;
    endtask

`ifdef MEM_STORE_BUFFER_EN
    task automatic test_store_buffer;
        int stall_cnt = 0;
        int guard     = 0;
        int req_in    = 0;
        bit done      = 0;
        bus_txn_t t;
        exp_bus_q.push_back(exp_txn(1'b1, 32'h300, 32'hCAFEF00D, 3'b010));
        exp_bus_q.push_back(exp_txn(1'b0, 32'h300, 32'h0, 3'b010));
        exp_rd_q.push_back(32'h5555AAAA);
        memwrite_m = 1'b1; addr_m = 32'h300; wdata_m = 32'hCAFEF00D; funct3_m = 3'b010;
        @(negedge clk);
        vectors++;
        if (stall_mem !== 1'b0) begin
            miscompares++;
            $display("FAIL sb_post_stall: got %b, want 0", stall_mem);
        end
        @(posedge clk); #1;
        memwrite_m = 1'b0; memread_m = 1'b1;
        while (!done && guard < 40) begin
            @(negedge clk);
            guard++;
            if (bus_req) begin
                req_in++;
                vectors++;
                if (exp_bus_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_unexpected_req: bus_req=1 with no pending transaction");
                end else begin
                    t = exp_bus_q[0];
                    if ({bus_we, bus_addr, bus_be} !== {t.we, t.addr, t.be} ||
                        (t.we && bus_wdata !== t.wdata)) begin
                        miscompares++;
                        $display("FAIL sb_order: got we=%b addr=%h wdata=%h, want we=%b addr=%h wdata=%h",
                                 bus_we, bus_addr, bus_wdata, t.we, t.addr, t.wdata);
                    end
                    if (req_in == (t.we ? 2 : 1)) begin
                        bus_ack = 1'b1;
                        bus_rdata = t.we ? 32'h0 : 32'h5555AAAA;
                        void'(exp_bus_q.pop_front());
                        req_in = 0;
                    end
                end
            end
            if (stall_mem) stall_cnt++;
            else begin
                done = 1;
                vectors++;
                if (rdata_m !== exp_rd_q[0]) begin
                    miscompares++;
                    $display("FAIL sb_load_rdata: got %h, want %h", rdata_m, exp_rd_q[0]);
                end
            end
            @(posedge clk); #1;
            bus_ack = 1'b0;
        end
        clear_inputs();
        vectors++;
        if (stall_cnt !== 4 || exp_bus_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_load_stall: got %0d cycles with %0d txns left, want 4 and 0",
                     stall_cnt, exp_bus_q.size());
        end
        exp_bus_q.delete();
        exp_rd_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_lw_zero_wait();
        test_load_ext();
`ifndef MEM_STORE_BUFFER_EN
        test_store();
`endif
        test_misaligned();
        test_back_to_back();
        test_reset_mid_req();
`ifdef MEM_STORE_BUFFER_EN
        test_store_buffer();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
